frame_traffic_scheduler: RTL and testbench
==========================================

# frame_traffic_scheduler

Sequences the PCS test frame generator over a traffic campaign. For each frame it produces the (data-block count, idle count, terminate position) tuple and hands it over with a valid/ready handshake. It then waits for the generator to report the frame sent, counts frames, and stops on a frame limit or on command. It sits between the test/control registers and the frame generator, and replaces the free-running noise source as the producer of ndata/nidle/nterm.

## Interface
- NB_DATA, 8, width of data-block count
- NB_IDLE, 5, width of idle count
- NB_TERM, 3, width of terminate position (0..7)
- NB_LFSR, 16, LFSR width (fixed polynomial below, must be 16)
- NB_FRAME_CNT, 16, frame counter / limit width
- LFSR_SEED, 16'hACE1, LFSR reset/start value (non-zero)

- i_clock  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  pulse: begin campaign (ignored while busy)
- i_stop  in  1  pulse: end campaign (ignored while idle)
- i_mode  in  2  00 fixed, 01 random, 10 terminate sweep, 11 treated as fixed
- i_fixed_ndata  in  NB_DATA  ndata in fixed/sweep modes
- i_fixed_nidle  in  NB_IDLE  nidle in fixed/sweep modes
- i_fixed_nterm  in  NB_TERM  nterm in fixed mode
- i_min_ndata  in  NB_DATA  lower clamp for random ndata
- i_nframes  in  NB_FRAME_CNT  frame limit; 0 = unlimited
- i_ready  in  1  generator accepts tuple
- i_frame_done  in  1  one-cycle pulse: generator emitted the terminate block of the current frame
- o_valid  out  1  tuple valid
- o_ndata  out  NB_DATA  data blocks in frame
- o_nidle  out  NB_IDLE  idle blocks after frame
- o_nterm  out  NB_TERM  terminate position
- o_enable  out  1  frame generator enable
- o_busy  out  1  campaign in progress
- o_frame_count  out  NB_FRAME_CNT  completed frames, saturating
- o_done  out  1  one-cycle pulse at campaign end

## Operation
- State machine: S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE. All outputs are registered.
- S_IDLE:
  - i_start goes to S_LOAD.
  - Clears o_frame_count, the sweep counter and stop_pending.
  - Reloads the LFSR with LFSR_SEED.
- S_LOAD (one cycle): latches the tuple, then goes to S_ISSUE. Tuple per mode:
  - Fixed: ndata, nidle and nterm come from the i_fixed_* inputs.
  - Random: ndata = max(lfsr[7:0], i_min_ndata), unsigned compare; nidle = lfsr[12:8]; nterm = lfsr[15:13].
  - Sweep: ndata and nidle are fixed; nterm = sweep counter.
- S_ISSUE:
  - o_valid=1; the tuple is held stable until o_valid&i_ready, then go to S_WAIT.
  - On the handshake: the LFSR advances one step, and the sweep counter increments mod 8.
  - If stop_pending and no handshake this cycle, go to S_DONE with no frame issued.
- S_WAIT:
  - On i_frame_done, o_frame_count increments (saturates at all-ones).
  - Then, if stop_pending or (i_nframes!=0 and the new count == i_nframes), go to S_DONE; else go to S_LOAD.
- S_DONE: o_done=1 for one cycle, then S_IDLE.
- LFSR: Fibonacci, shift left, bit0 = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]. It advances only on an accepted handshake.
- stop_pending is set by i_stop in S_LOAD/S_ISSUE/S_WAIT.
- Boundary rules:
  - i_stop together with a handshake in S_ISSUE: the handshake wins, the frame completes, then S_DONE.
  - i_frame_done outside S_WAIT is ignored.
  - i_start while busy is ignored.
  - Mode and fixed inputs are sampled only in S_LOAD.

## Timing
- Reset: state S_IDLE, lfsr=LFSR_SEED, every output 0.
- Reset asserted mid-campaign returns everything to reset values immediately. No o_done is generated.
- i_start sampled at edge k:
  - o_busy=1 and o_enable=1 after edge k.
  - o_valid=1 with the tuple after edge k+1.
- Handshake at edge m: o_valid=0 after edge m.
- i_frame_done at edge n:
  - o_frame_count is updated after edge n.
  - If the campaign continues, the next o_valid follows after edge n+2.
- Campaign end:
  - o_done is high in the cycle after the last count update.
  - o_busy and o_enable drop after that cycle.
- o_busy and o_enable are high in S_LOAD, S_ISSUE and S_WAIT.

## Test plan
- Reset, then 10 idle cycles -> all outputs 0; i_stop and i_frame_done have no effect.
- Fixed mode, ndata=10, nidle=4, nterm=3, nframes=3, i_ready=1, i_frame_done 5 cycles after each handshake -> three tuples (10,4,3); o_frame_count=3; one o_done pulse; o_enable low afterwards.
- Random mode, min_ndata=0x40 -> tuples (0xE1,12,5) then (0xC3,25,2); LFSR 0xACE1 -> 0x59C3. Repeat with min_ndata=0xF0 -> first ndata=0xF0.
- Backpressure: i_ready low for 4 cycles in S_ISSUE -> o_valid and the tuple stay constant, the LFSR does not advance, one handshake when ready rises.
- Stop: nframes=0, i_stop in S_WAIT -> frame completes, count+1, then o_done. i_stop in S_ISSUE with i_ready=0 -> S_DONE, count unchanged, no handshake.
- Sweep mode over 9 frames -> nterm 0,1,…,7,0. Async reset asserted in S_WAIT of frame 5 -> outputs 0 immediately; a new i_start restarts nterm at 0 and the count at 0.

Source files
------------

// File: rtl/frame_traffic_scheduler.sv
// Per-frame (ndata, nidle, nterm) tuple source for the PCS test frame generator:
// fixed / random / terminate-sweep campaigns with a frame limit and stop control.
module frame_traffic_scheduler #(
    parameter int unsigned        NB_DATA      = 8,
    parameter int unsigned        NB_IDLE      = 5,
    parameter int unsigned        NB_TERM      = 3,
    parameter int unsigned        NB_LFSR      = 16,
    parameter int unsigned        NB_FRAME_CNT = 16,
    parameter logic [NB_LFSR-1:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic [1:0]              i_mode,
    input  logic [NB_DATA-1:0]      i_fixed_ndata,
    input  logic [NB_IDLE-1:0]      i_fixed_nidle,
    input  logic [NB_TERM-1:0]      i_fixed_nterm,
    input  logic [NB_DATA-1:0]      i_min_ndata,
    input  logic [NB_FRAME_CNT-1:0] i_nframes,
    input  logic                    i_ready,
    input  logic                    i_frame_done,
    output logic                    o_valid,
    output logic [NB_DATA-1:0]      o_ndata,
    output logic [NB_IDLE-1:0]      o_nidle,
    output logic [NB_TERM-1:0]      o_nterm,
    output logic                    o_enable,
    output logic                    o_busy,
    output logic [NB_FRAME_CNT-1:0] o_frame_count,
    output logic                    o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_RANDOM = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [NB_FRAME_CNT-1:0] CNT_MAX = {NB_FRAME_CNT{1'b1}};

    // Fibonacci step, taps 16/14/13/11
    function automatic logic [NB_LFSR-1:0] lfsr_step(input logic [NB_LFSR-1:0] cur);
        return {cur[NB_LFSR-2:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

    state_t                  state_q, state_d;
    logic [NB_LFSR-1:0]      lfsr_q, lfsr_d;
    logic [NB_TERM-1:0]      sweep_q, sweep_d;
    logic [NB_FRAME_CNT-1:0] count_q, count_d;
    logic                    stop_pending_q, stop_pending_d;
    logic                    done_seen_q, done_seen_d;
    logic [NB_DATA-1:0]      ndata_q, ndata_d;
    logic [NB_IDLE-1:0]      nidle_q, nidle_d;
    logic [NB_TERM-1:0]      nterm_q, nterm_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    handshake_s;
    logic                    limit_hit_s;
    logic [NB_DATA-1:0]      rnd_ndata_s;
    logic [NB_IDLE-1:0]      rnd_nidle_s;
    logic [NB_TERM-1:0]      rnd_nterm_s;

    assign handshake_s = (state_q == S_ISSUE) && valid_q && i_ready;
    assign limit_hit_s = (i_nframes != {NB_FRAME_CNT{1'b0}}) && (count_q == i_nframes);
    assign rnd_ndata_s = lfsr_q[NB_DATA-1:0];
    assign rnd_nidle_s = lfsr_q[NB_DATA+NB_IDLE-1:NB_DATA];
    assign rnd_nterm_s = lfsr_q[NB_LFSR-1:NB_DATA+NB_IDLE];

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the limit/stop decision in S_WAIT is taken the cycle after
    // the count update so it sees the new count
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_LOAD;
                else         state_d = S_IDLE;
            end
            S_LOAD: state_d = S_ISSUE;
            S_ISSUE: begin
                if (handshake_s)         state_d = S_WAIT;
                else if (stop_pending_q) state_d = S_DONE;
                else                     state_d = S_ISSUE;
            end
            S_WAIT: begin
                if (done_seen_q) begin
                    if (stop_pending_q || limit_hit_s) state_d = S_DONE;
                    else                               state_d = S_LOAD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: tuple latch, LFSR, sweep counter, frame count, stop flag
    always_comb begin
        lfsr_d         = lfsr_q;
        sweep_d        = sweep_q;
        count_d        = count_q;
        stop_pending_d = stop_pending_q;
        done_seen_d    = done_seen_q;
        ndata_d        = ndata_q;
        nidle_d        = nidle_q;
        nterm_d        = nterm_q;
        case (state_q)
            S_IDLE: begin
                lfsr_d         = LFSR_SEED;
                sweep_d        = {NB_TERM{1'b0}};
                count_d        = {NB_FRAME_CNT{1'b0}};
                stop_pending_d = 1'b0;
                done_seen_d    = 1'b0;
            end
            S_LOAD: begin
                stop_pending_d = stop_pending_q | i_stop;
                done_seen_d    = 1'b0;
                if (i_mode == MODE_RANDOM) begin
                    ndata_d = (rnd_ndata_s < i_min_ndata) ? i_min_ndata : rnd_ndata_s;
                    nidle_d = rnd_nidle_s;
                    nterm_d = rnd_nterm_s;
                end else if (i_mode == MODE_SWEEP) begin
                    ndata_d = i_fixed_ndata;
                    nidle_d = i_fixed_nidle;
                    nterm_d = sweep_q;
                end else begin
                    ndata_d = i_fixed_ndata;
                    nidle_d = i_fixed_nidle;
                    nterm_d = i_fixed_nterm;
                end
            end
            S_ISSUE: begin
                stop_pending_d = stop_pending_q | i_stop;
                if (handshake_s) begin
                    lfsr_d  = lfsr_step(lfsr_q);
                    sweep_d = sweep_q + NB_TERM'(1);
                end else begin
                    lfsr_d  = lfsr_q;
                    sweep_d = sweep_q;
                end
            end
            S_WAIT: begin
                stop_pending_d = stop_pending_q | i_stop;
                if (!done_seen_q && i_frame_done) begin
                    done_seen_d = 1'b1;
                    if (count_q != CNT_MAX) count_d = count_q + NB_FRAME_CNT'(1);
                    else                    count_d = count_q;
                end else begin
                    done_seen_d = done_seen_q;
                end
            end
            S_DONE: begin
                done_seen_d = 1'b0;
            end
            default: begin
                done_seen_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            lfsr_q         <= LFSR_SEED;
            sweep_q        <= {NB_TERM{1'b0}};
            count_q        <= {NB_FRAME_CNT{1'b0}};
            stop_pending_q <= 1'b0;
            done_seen_q    <= 1'b0;
            ndata_q        <= {NB_DATA{1'b0}};
            nidle_q        <= {NB_IDLE{1'b0}};
            nterm_q        <= {NB_TERM{1'b0}};
        end else begin
            lfsr_q         <= lfsr_d;
            sweep_q        <= sweep_d;
            count_q        <= count_d;
            stop_pending_q <= stop_pending_d;
            done_seen_q    <= done_seen_d;
            ndata_q        <= ndata_d;
            nidle_q        <= nidle_d;
            nterm_q        <= nterm_d;
        end
    end

    // Output decode from the next state so flags line up with the state they describe
    always_comb begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            S_LOAD:  busy_d = 1'b1;
            S_ISSUE: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
            end
            S_WAIT:  busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            S_IDLE:  busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    // Output flag registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_ndata       = ndata_q;
    assign o_nidle       = nidle_q;
    assign o_nterm       = nterm_q;
    assign o_enable      = busy_q;
    assign o_busy        = busy_q;
    assign o_frame_count = count_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_frame_traffic_scheduler.sv
// Bench for frame_traffic_scheduler: single-frame vector table plus multi-frame
// sequences; issued tuples are checked against a scoreboard queue at each handshake.
module tb_frame_traffic_scheduler;

    typedef struct packed {
        logic [7:0] nd;
        logic [4:0] ni;
        logic [2:0] nt;
    } tuple_t;

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [7:0] fnd;
        logic [4:0] fni;
        logic [2:0] fnt;
        logic [7:0] mnd;
        tuple_t     exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic [7:0]  i_fixed_ndata = 8'd0;
    logic [4:0]  i_fixed_nidle = 5'd0;
    logic [2:0]  i_fixed_nterm = 3'd0;
    logic [7:0]  i_min_ndata = 8'd0;
    logic [15:0] i_nframes = 16'd0;
    logic        i_ready = 1'b1;
    logic        i_frame_done = 1'b0;
    logic        o_valid;
    logic [7:0]  o_ndata;
    logic [4:0]  o_nidle;
    logic [2:0]  o_nterm;
    logic        o_enable;
    logic        o_busy;
    logic [15:0] o_frame_count;
    logic        o_done;
    logic [35:0] all_outs;

    tuple_t exp_q[$];
    vec_t   vecs[7];
    int     n_cmp = 0;
    int     n_fail = 0;

    always #5 clk = ~clk;

    frame_traffic_scheduler dut (
        .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
        .i_mode(i_mode), .i_fixed_ndata(i_fixed_ndata), .i_fixed_nidle(i_fixed_nidle),
        .i_fixed_nterm(i_fixed_nterm), .i_min_ndata(i_min_ndata), .i_nframes(i_nframes),
        .i_ready(i_ready), .i_frame_done(i_frame_done), .o_valid(o_valid),
        .o_ndata(o_ndata), .o_nidle(o_nidle), .o_nterm(o_nterm), .o_enable(o_enable),
        .o_busy(o_busy), .o_frame_count(o_frame_count), .o_done(o_done)
    );

    assign all_outs = {o_valid, o_ndata, o_nidle, o_nterm, o_enable, o_busy, o_frame_count, o_done};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each accepted tuple must match the next expected one
    always @(negedge clk) begin
        if (i_reset && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: got tuple %0h/%0h/%0h, want none", o_ndata, o_nidle, o_nterm);
            end else begin
                check("sb_tuple", 64'({o_ndata, o_nidle, o_nterm}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_hs(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (o_valid && i_ready) ok = 1'b1;
            tick();
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got no handshake, want one within 40 cycles", name);
        end
    endtask

    task automatic send_done(input int delay);
        repeat (delay) tick();
        i_frame_done = 1'b1;
        tick();
        i_frame_done = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [15:0] exp_cnt);
        bit ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (o_done) ok = 1'b1;
            else        tick();
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got no o_done, want pulse within 30 cycles", name);
        end else begin
            check({name, "_count"}, 64'(o_frame_count), 64'(exp_cnt));
        end
        tick();
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [7:0] nd, input logic [4:0] ni,
                           input logic [2:0] nt, input logic [7:0] mn, input logic [15:0] nf);
        i_mode = m; i_fixed_ndata = nd; i_fixed_nidle = ni; i_fixed_nterm = nt;
        i_min_ndata = mn; i_nframes = nf;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"fixed",       2'd0, 8'd10,  5'd4,  3'd3, 8'h00, '{8'd10,  5'd4,  3'd3}};
        vecs[1] = '{"mode3_fixed", 2'd3, 8'd7,   5'd31, 3'd7, 8'h00, '{8'd7,   5'd31, 3'd7}};
        vecs[2] = '{"rnd_min40",   2'd1, 8'd1,   5'd1,  3'd1, 8'h40, '{8'hE1,  5'd12, 3'd5}};
        vecs[3] = '{"rnd_minF0",   2'd1, 8'd1,   5'd1,  3'd1, 8'hF0, '{8'hF0,  5'd12, 3'd5}};
        vecs[4] = '{"rnd_minE1",   2'd1, 8'd1,   5'd1,  3'd1, 8'hE1, '{8'hE1,  5'd12, 3'd5}};
        vecs[5] = '{"rnd_minE2",   2'd1, 8'd1,   5'd1,  3'd1, 8'hE2, '{8'hE2,  5'd12, 3'd5}};
        vecs[6] = '{"sweep_first", 2'd2, 8'd20,  5'd9,  3'd6, 8'h00, '{8'd20,  5'd9,  3'd0}};

        repeat (3) tick();
        check("reset_outs", 64'(all_outs), 64'd0);
        i_reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            i_stop = c[0];
            i_frame_done = ~c[0];
            tick();
            check("idle_outs", 64'(all_outs), 64'd0);
        end
        i_stop = 1'b0;
        i_frame_done = 1'b0;

        for (int r = 0; r < 7; r++) begin
            set_cfg(vecs[r].mode, vecs[r].fnd, vecs[r].fni, vecs[r].fnt, vecs[r].mnd, 16'd1);
            exp_q.push_back(vecs[r].exp);
            do_start();
            wait_hs(vecs[r].name);
            send_done(3);
            tick();
            check({vecs[r].name, "_done"}, 64'(o_done), 64'd1);
            check({vecs[r].name, "_count"}, 64'(o_frame_count), 64'd1);
            tick();
        end

        // Fixed mode, three frames, with start/reissue latency checks
        set_cfg(2'd0, 8'd10, 5'd4, 3'd3, 8'd0, 16'd3);
        for (int f = 0; f < 3; f++) exp_q.push_back('{8'd10, 5'd4, 3'd3});
        do_start();
        check("start_busy_en", 64'({o_busy, o_enable, o_valid}), 64'(3'b110));
        tick();
        check("start_valid", 64'(o_valid), 64'd1);
        for (int f = 0; f < 3; f++) begin
            wait_hs("fixed3_hs");
            check("hs_valid_low", 64'(o_valid), 64'd0);
            send_done(5);
            check("fixed3_count", 64'(o_frame_count), 64'(f + 1));
            if (f < 2) begin
                tick();
                check("reissue_n1", 64'(o_valid), 64'd0);
                tick();
                check("reissue_n2", 64'(o_valid), 64'd1);
            end
        end
        tick();
        check("fixed3_done", 64'({o_done, o_busy, o_enable}), 64'(3'b100));
        check("fixed3_count_end", 64'(o_frame_count), 64'd3);
        tick();
        check("fixed3_after", 64'({o_done, o_enable}), 64'd0);

        // Random mode with backpressure: tuple held, LFSR advances once per handshake
        set_cfg(2'd1, 8'd0, 5'd0, 3'd0, 8'h40, 16'd2);
        exp_q.push_back('{8'hE1, 5'd12, 3'd5});
        exp_q.push_back('{8'hC3, 5'd25, 3'd2});
        i_ready = 1'b0;
        do_start();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_hold", 64'({o_valid, o_ndata, o_nidle, o_nterm}), 64'({1'b1, 8'hE1, 5'd12, 3'd5}));
            tick();
        end
        i_ready = 1'b1;
        wait_hs("bp_hs1");
        send_done(2);
        wait_hs("bp_hs2");
        send_done(2);
        wait_done("bp", 16'd2);

        // Stop while waiting for the frame: frame still counts
        set_cfg(2'd0, 8'd10, 5'd4, 3'd3, 8'd0, 16'd0);
        exp_q.push_back('{8'd10, 5'd4, 3'd3});
        do_start();
        wait_hs("stopw_hs");
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        send_done(3);
        check("stopw_count", 64'(o_frame_count), 64'd1);
        tick();
        check("stopw_done", 64'(o_done), 64'd1);
        tick();

        // Stop in issue with no ready: ends with nothing issued
        i_ready = 1'b0;
        do_start();
        tick();
        check("stopi_valid", 64'(o_valid), 64'd1);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("stopi_pending_valid", 64'(o_valid), 64'd1);
        tick();
        check("stopi_done", 64'({o_done, o_valid, o_frame_count}), 64'({1'b1, 1'b0, 16'd0}));
        tick();
        i_ready = 1'b1;

        // Stop coincident with handshake: handshake wins, frame completes
        exp_q.push_back('{8'd10, 5'd4, 3'd3});
        do_start();
        tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("stophs_valid", 64'(o_valid), 64'd0);
        send_done(2);
        tick();
        check("stophs_done", 64'({o_done, o_frame_count}), 64'({1'b1, 16'd1}));
        tick();

        // Sweep over nine frames wraps nterm
        set_cfg(2'd2, 8'd20, 5'd9, 3'd6, 8'd0, 16'd9);
        for (int f = 0; f < 9; f++) exp_q.push_back('{8'd20, 5'd9, 3'(f % 8)});
        do_start();
        for (int f = 0; f < 9; f++) begin
            wait_hs("sweep_hs");
            send_done(2);
        end
        wait_done("sweep9", 16'd9);

        // Async reset mid-campaign, then restart from scratch
        i_nframes = 16'd0;
        for (int f = 0; f < 5; f++) exp_q.push_back('{8'd20, 5'd9, 3'(f)});
        do_start();
        for (int f = 0; f < 5; f++) begin
            wait_hs("rst_hs");
            if (f < 4) send_done(2);
        end
        tick();
        i_reset = 1'b0;
        #1;
        check("async_reset_outs", 64'(all_outs), 64'd0);
        tick();
        check("reset_hold_outs", 64'(all_outs), 64'd0);
        i_reset = 1'b1;
        tick();
        check("reset_no_done", 64'(all_outs), 64'd0);
        i_nframes = 16'd1;
        exp_q.push_back('{8'd20, 5'd9, 3'd0});
        do_start();
        wait_hs("restart_hs");
        send_done(2);
        wait_done("restart", 16'd1);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
